// File: rtl/uart_pkg.sv
// Shared constants for the uart_tx arbiter: byte width, default busy timeout and FSM encodings.
package uart_pkg;

  localparam int BYTE_W           = 8;
  localparam int DEF_BUSY_TIMEOUT = 16;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WAIT_BUSY = 2'd1;
  localparam logic [1:0] ST_WAIT_DONE = 2'd2;
  localparam logic [1:0] ST_HOLD      = 2'd3;

endpackage

// File: rtl/rr_pick.sv
// Combinational rotate-priority encoder: first set request at or after rr_ptr, wrapping.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [IDX_W-1:0]   win_idx,
  output logic               win_valid
);

  logic [IDX_W-1:0] cand;

  // Scan from the farthest offset down so the nearest set request is the last one written.
  always_comb begin
    win_idx   = '0;
    win_valid = 1'b0;
    cand      = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = IDX_W'((int'(rr_ptr) + i) % NUM_REQ);
      if (req[cand]) begin
        win_valid = 1'b1;
        win_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between NUM_REQ requesters, with per-owner frame lock.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int IDX_W        = 2,
  parameter int BUSY_TIMEOUT = DEF_BUSY_TIMEOUT
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*BYTE_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_lock,
  output logic [NUM_REQ-1:0]        ack,
  input  logic                      tx_busy,
  output logic                      tx_start,
  output logic [BYTE_W-1:0]         tx_data,
  output logic [IDX_W-1:0]          owner,
  output logic                      owner_valid,
  output logic                      err
);

  localparam int               CNT_W    = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  logic [1:0]         state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               tx_start_q, tx_start_d;
  logic [BYTE_W-1:0]  tx_data_q, tx_data_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic               err_q, err_d;

  logic [IDX_W-1:0] win_idx;
  logic             win_valid;
  logic             launch, rel;
  logic [IDX_W-1:0] launch_idx;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req       (req),
    .rr_ptr    (rr_ptr_q),
    .win_idx   (win_idx),
    .win_valid (win_valid)
  );

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    cnt_d      = cnt_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    ack_d      = '0;
    err_d      = 1'b0;
    launch     = 1'b0;
    rel        = 1'b0;
    launch_idx = owner_q;

    case (state_q)
      ST_IDLE: begin
        if (win_valid && !tx_busy) begin
          launch     = 1'b1;
          launch_idx = win_idx;
        end
      end
      ST_WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = ST_WAIT_DONE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(BUSY_TIMEOUT - 1)) begin
          err_d = 1'b1;
          rel   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (!tx_busy) begin
          if (req_lock[owner_q] && req[owner_q]) begin
            launch = 1'b1;
          end else if (req_lock[owner_q]) begin
            state_d = ST_HOLD;
          end else begin
            rel = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        // A pending byte beats a lock drop; the lock is looked at again after that byte.
        if (req[owner_q]) begin
          launch = 1'b1;
        end else if (!req_lock[owner_q]) begin
          rel = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (launch) begin
      state_d             = ST_WAIT_BUSY;
      tx_start_d          = 1'b1;
      tx_data_d           = req_data[launch_idx*BYTE_W +: BYTE_W];
      ack_d[launch_idx]   = 1'b1;
      owner_d             = launch_idx;
      cnt_d               = '0;
    end

    if (rel) begin
      state_d  = ST_IDLE;
      rr_ptr_d = (owner_q == LAST_IDX) ? '0 : owner_q + IDX_W'(1);
      cnt_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      cnt_q      <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      ack_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      cnt_q      <= cnt_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
    end
  end

  assign tx_start    = tx_start_q;
  assign tx_data     = tx_data_q;
  assign ack         = ack_q;
  assign owner       = owner_q;
  assign owner_valid = (state_q != ST_IDLE);
  assign err         = err_q;

endmodule
